// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter.
// One double-dabble iteration per clock; digits only update on completion.
module bin_to_bcd_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] bin_in_i,
  output logic [3:0] bcd_hund_o,
  output logic [3:0] bcd_tens_o,
  output logic [3:0] bcd_ones_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] scr_q, scr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [11:0] adj;

  function automatic logic [3:0] fix(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Add-3 correction on every nibble before the shift.
  assign adj = {fix(scr_q[11:8]), fix(scr_q[7:4]), fix(scr_q[3:0])};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d = bin_in_i;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d   = {adj[10:0], shreg_q[7]};
        shreg_d = {shreg_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          hund_d  = scr_d[11:8];
          tens_d  = scr_d[7:4];
          ones_d  = scr_d[3:0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign bcd_hund_o = hund_q;
  assign bcd_tens_o = tens_q;
  assign bcd_ones_o = ones_q;
  assign busy_o     = (state_q == SHIFT);
  assign done_o     = (state_q == DONE);

endmodule
